// File: rtl/ex_stage_arbiter.sv
// ex_stage_arbiter: round-robin sharing of the single execute stage
// between requesters, with an optional memory read before each op.
module ex_stage_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 7,
    parameter int MEM_TIMEOUT = 15,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
    input  logic [NUM_REQ*DATA_W-1:0] req_src1,
    input  logic [NUM_REQ*DATA_W-1:0] req_src2,
    input  logic [NUM_REQ*DATA_W-1:0] req_imm,
    output logic                      ex_en,
    output logic [CTRL_W-1:0]         ex_ctrl,
    output logic [DATA_W-1:0]         ex_src1,
    output logic [DATA_W-1:0]         ex_src2,
    output logic [DATA_W-1:0]         ex_imm,
    output logic [DATA_W-1:0]         ex_mem_rdata,
    input  logic [DATA_W-1:0]         ex_aluout,
    input  logic                      ex_carry,
    output logic                      mem_req,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_carry,
    output logic                      resp_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        MEM_WAIT,
        ISSUE,
        EXEC,
        RESP
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                ex_en_q;
    logic [CTRL_W-1:0]   ex_ctrl_q;
    logic [DATA_W-1:0]   ex_src1_q;
    logic [DATA_W-1:0]   ex_src2_q;
    logic [DATA_W-1:0]   ex_imm_q;
    logic [DATA_W-1:0]   ex_mem_rdata_q;
    logic                mem_req_q;
    logic                resp_valid_q;
    logic [ID_W-1:0]     resp_id_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                resp_carry_q;
    logic                resp_err_q;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [CTRL_W-1:0]   g_ctrl;
    logic [DATA_W-1:0]   g_src1;
    logic [DATA_W-1:0]   g_src2;
    logic [DATA_W-1:0]   g_imm;

    // First valid requester at or after rr_ptr, wrapping around
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && req_valid[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        g_ctrl = '0;
        g_src1 = '0;
        g_src2 = '0;
        g_imm  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                g_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
                g_src1 = req_src1[i*DATA_W +: DATA_W];
                g_src2 = req_src2[i*DATA_W +: DATA_W];
                g_imm  = req_imm[i*DATA_W +: DATA_W];
            end
        end
    end

    // Accept is only offered while idle and never during reset
    always_comb begin
        req_ready = '0;
        if (reset && state_q == IDLE && win_found)
            req_ready[win_id] = 1'b1;
    end

    // Pointer moves just past the requester that was serviced
    always_comb begin
        if (resp_id_q == ID_W'(NUM_REQ - 1))
            rr_ptr_d = '0;
        else
            rr_ptr_d = resp_id_q + 1'b1;
    end

    // Sequencer: grant, optional memory read, issue, capture, respond
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
            ex_en_q        <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_src1_q      <= '0;
            ex_src2_q      <= '0;
            ex_imm_q       <= '0;
            ex_mem_rdata_q <= '0;
            mem_req_q      <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_data_q    <= '0;
            resp_carry_q   <= 1'b0;
            resp_err_q     <= 1'b0;
        end else begin
            ex_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        ex_ctrl_q <= g_ctrl;
                        ex_src1_q <= g_src1;
                        ex_src2_q <= g_src2;
                        ex_imm_q  <= g_imm;
                        resp_id_q <= win_id;
                        if (g_ctrl[CTRL_W-1]) begin
                            mem_req_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= MEM_WAIT;
                        end else begin
                            ex_en_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        ex_mem_rdata_q <= mem_rdata;
                        cnt_q          <= '0;
                        mem_req_q      <= 1'b0;
                        ex_en_q        <= 1'b1;
                        state_q        <= ISSUE;
                    end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                        cnt_q        <= '0;
                        mem_req_q    <= 1'b0;
                        resp_data_q  <= '0;
                        resp_carry_q <= 1'b0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ISSUE: state_q <= EXEC;
                EXEC: begin
                    resp_data_q  <= ex_aluout;
                    resp_carry_q <= ex_carry;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= rr_ptr_d;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_en        = ex_en_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_src1      = ex_src1_q;
    assign ex_src2      = ex_src2_q;
    assign ex_imm       = ex_imm_q;
    assign ex_mem_rdata = ex_mem_rdata_q;
    assign mem_req      = mem_req_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_data    = resp_data_q;
    assign resp_carry   = resp_carry_q;
    assign resp_err     = resp_err_q;

endmodule
